// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one request at a time to instruction
// memory, holds the returned instruction for decode, and squashes fetches on redirect.
module fetch_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc,
  output logic [6:0]      opcode,
  output logic [2:0]      funct3,
  output logic [6:0]      funct7,
  output logic            misaligned_err,
  output logic [31:0]     fetch_count
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_HOLD = 3'd3,
    S_DROP = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;
  logic [XLEN-1:0] inst_q, inst_d;
  logic [XLEN-1:0] inst_pc_q, inst_pc_d;
  logic            misaligned_q, misaligned_d;
  logic [31:0]     fetch_count_q, fetch_count_d;

  logic            redirect_take;
  logic [XLEN-1:0] redirect_aligned;

  // The IDLE cycle after reset ignores redirects; every other state honours them.
  assign redirect_take    = redirect_valid && (state_q != S_IDLE);
  assign redirect_aligned = {redirect_pc[XLEN-1:2], 2'b00};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      pc_q          <= RESET_PC;
      req_pc_q      <= RESET_PC;
      inst_q        <= '0;
      inst_pc_q     <= '0;
      misaligned_q  <= 1'b0;
      fetch_count_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      req_pc_q      <= req_pc_d;
      inst_q        <= inst_d;
      inst_pc_q     <= inst_pc_d;
      misaligned_q  <= misaligned_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    req_pc_d      = req_pc_q;
    inst_d        = inst_q;
    inst_pc_d     = inst_pc_q;
    fetch_count_d = fetch_count_q;
    misaligned_d  = misaligned_q | (redirect_take && (redirect_pc[1:0] != 2'b00));

    if (redirect_take) begin
      pc_d = redirect_aligned;
    end

    case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        if (!redirect_valid && imem_req_ready) begin
          req_pc_d = pc_q;
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_rsp_valid && !redirect_valid) begin
          inst_d    = imem_rsp_data;
          inst_pc_d = req_pc_q;
          state_d   = S_HOLD;
        end else if (imem_rsp_valid) begin
          state_d = S_REQ;
        end else if (redirect_valid) begin
          state_d = S_DROP;
        end
      end
      // A response and a redirect together still retire the stale request.
      S_DROP: begin
        if (imem_rsp_valid) begin
          state_d = S_REQ;
        end
      end
      S_HOLD: begin
        if (redirect_valid) begin
          state_d = S_REQ;
        end else if (inst_ready) begin
          pc_d          = inst_pc_q + XLEN'(4);
          fetch_count_d = fetch_count_q + 32'd1;
          state_d       = S_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign imem_req_valid = (state_q == S_REQ) && !redirect_valid;
  assign imem_req_addr  = pc_q;
  assign inst_valid     = (state_q == S_HOLD) && !redirect_valid;
  assign inst           = inst_q;
  assign inst_pc        = inst_pc_q;
  assign opcode         = inst_q[6:0];
  assign funct3         = inst_q[14:12];
  assign funct7         = inst_q[31:25];
  assign misaligned_err = misaligned_q;
  assign fetch_count    = fetch_count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: a memory/decode environment driven by $urandom and
// a transaction-level model of what the fetch stage must present each cycle.
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic        misaligned_err;
  logic [31:0] fetch_count;

  fetch_unit #(.XLEN(32), .RESET_PC(RST_PC)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .opcode         (opcode),
    .funct3         (funct3),
    .funct7         (funct7),
    .misaligned_err (misaligned_err),
    .fetch_count    (fetch_count)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: what the fetch stage owes its environment, in transaction terms.
  logic [31:0] pc_m;          // address of the next instruction to fetch
  logic        idle_m;        // first cycle after reset release
  logic        have_inst_m;   // an instruction is owed to decode
  logic [31:0] inst_m, ipc_m;
  logic        outstanding_m; // request accepted, response not yet returned
  logic        live_m;        // that response is still wanted
  logic [31:0] out_addr_m;
  int          timer_m;
  logic        mis_m;
  logic [31:0] cnt_m;
  logic        inject_late;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h0019_660D) + 32'h3C6E_F35F;
  endfunction

  task automatic model_reset();
    pc_m = RST_PC; idle_m = 1'b1; have_inst_m = 1'b0; inst_m = '0; ipc_m = '0;
    outstanding_m = 1'b0; live_m = 1'b0; out_addr_m = '0; timer_m = 0;
    mis_m = 1'b0; cnt_m = '0;
  endtask

  task automatic check_reset_outputs();
    check("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
    check("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
    check("rst_req_addr", imem_req_addr, RST_PC);
    check("rst_inst", inst, 32'd0);
    check("rst_inst_pc", inst_pc, 32'd0);
    check("rst_misaligned", {31'd0, misaligned_err}, 32'd0);
    check("rst_fetch_count", fetch_count, 32'd0);
  endtask

  // Called at a negedge; returns at a negedge with rst_n just released.
  task automatic do_reset();
    rst_n = 1'b0;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; redirect_valid = 1'b0; inst_ready = 1'b0;
    #1 check_reset_outputs();
    @(negedge clk);
    #1 check_reset_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    inject_late = 1'b1;
    $display("reset released");
  endtask

  // One clock cycle of environment drive, output checks and model update.
  task automatic step(input logic allow_redir);
    logic        rdy, irdy, redir, rsp, fire, exp_req_v, exp_inst_v;
    logic [31:0] tgt, data;
    int          r;
    rdy   = ($urandom_range(0, 3) != 0);
    irdy  = ($urandom_range(0, 2) != 0);
    redir = allow_redir && !idle_m && ($urandom_range(0, 9) == 0);
    r     = $urandom_range(0, 15);
    if (r == 0)      tgt = $urandom;
    else if (r == 1) tgt = 32'hFFFF_FFFC;
    else             tgt = $urandom & 32'h0000_FFFC;
    rsp  = outstanding_m && (timer_m == 1);
    data = rsp ? mem_word(out_addr_m) : $urandom;
    if (idle_m && inject_late) rsp = 1'b1;

    imem_req_ready = rdy;
    inst_ready     = irdy;
    redirect_valid = redir;
    redirect_pc    = tgt;
    imem_rsp_valid = rsp;
    imem_rsp_data  = data;
    #1;

    exp_req_v  = !idle_m && !have_inst_m && !outstanding_m && !redir;
    exp_inst_v = have_inst_m && !redir;
    check("req_valid", {31'd0, imem_req_valid}, {31'd0, exp_req_v});
    if (exp_req_v) check("req_addr", imem_req_addr, pc_m);
    check("inst_valid", {31'd0, inst_valid}, {31'd0, exp_inst_v});
    if (exp_inst_v) begin
      check("inst", inst, inst_m);
      check("inst_pc", inst_pc, ipc_m);
      check("opcode", {25'd0, opcode}, {25'd0, inst_m[6:0]});
      check("funct3", {29'd0, funct3}, {29'd0, inst_m[14:12]});
      check("funct7", {25'd0, funct7}, {25'd0, inst_m[31:25]});
    end
    check("fetch_count", fetch_count, cnt_m);
    check("misaligned", {31'd0, misaligned_err}, {31'd0, mis_m});

    if (idle_m) begin
      idle_m = 1'b0;
      inject_late = 1'b0;
    end else begin
      fire = exp_req_v && rdy;
      if (exp_inst_v && irdy) begin
        $display("consume pc=%h inst=%h count=%0d", ipc_m, inst_m, cnt_m + 1);
        cnt_m = cnt_m + 1;
        pc_m = ipc_m + 32'd4;
        have_inst_m = 1'b0;
      end
      if (outstanding_m && rsp) begin
        if (live_m && !redir) begin
          have_inst_m = 1'b1;
          inst_m = data;
          ipc_m = out_addr_m;
        end
        outstanding_m = 1'b0;
      end
      if (redir) begin
        pc_m = {tgt[31:2], 2'b00};
        if (tgt[1:0] != 2'b00) mis_m = 1'b1;
        have_inst_m = 1'b0;
        live_m = 1'b0;
      end
      if (fire) begin
        outstanding_m = 1'b1;
        live_m = 1'b1;
        out_addr_m = pc_m;
        timer_m = ($urandom_range(0, 1) == 0) ? 1 : $urandom_range(2, 4);
      end else if (outstanding_m) begin
        timer_m = timer_m - 1;
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    redirect_valid = 1'b0; redirect_pc = '0; inst_ready = 1'b0;
    inject_late = 1'b0;
    model_reset();
    @(negedge clk);
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc != 0) @(negedge clk);
      if ((cyc % 500) == 450) do_reset();
      step(cyc >= 20);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage directly upstream of the decode/control logic.
- Holds the PC and issues requests to instruction memory over a valid/ready request and valid-only response interface.
- Presents one instruction at a time to decode with a valid/ready handshake, and exposes the pre-sliced opcode/funct3/funct7 fields the control unit consumes.
- Accepts PC redirects (taken branches) and discards stale in-flight fetches.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset; bits [1:0] must be 0.
- XLEN, 32, PC/address/instruction width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  XLEN  fetch address, equals pc.
- imem_rsp_valid  in  1  response data valid; one response per accepted request, ≥1 cycle after acceptance.
- imem_rsp_data  in  XLEN  fetched instruction.
- redirect_valid  in  1  load new PC (taken branch).
- redirect_pc  in  XLEN  redirect target.
- inst_valid  out  1  instruction available to decode.
- inst_ready  in  1  decode consumes instruction.
- inst  out  XLEN  held instruction.
- inst_pc  out  XLEN  PC of held instruction.
- opcode  out  7  inst[6:0].
- funct3  out  3  inst[14:12].
- funct7  out  7  inst[31:25].
- misaligned_err  out  1  sticky: a redirect target had bits [1:0] != 0.
- fetch_count  out  32  number of instructions consumed by decode.

Behaviour:
- Reset (rst_n low, async):
  - state=S_IDLE, pc=RESET_PC, inst/inst_pc=0, misaligned_err=0, fetch_count=0.
  - All valid outputs are 0.
- States: S_IDLE, S_REQ, S_WAIT, S_HOLD, S_DROP.
- S_IDLE: unconditionally → S_REQ on the next edge. This gives one dead cycle after reset release.
- S_REQ:
  - imem_req_valid = !redirect_valid.
  - redirect_valid: pc <= aligned redirect_pc, stay in S_REQ; no handshake occurs that cycle.
  - Otherwise, on imem_req_ready: req_pc <= pc, → S_WAIT.
- S_WAIT:
  - imem_rsp_valid && !redirect_valid: inst <= imem_rsp_data, inst_pc <= req_pc, → S_HOLD.
  - imem_rsp_valid && redirect_valid: discard data, pc <= redirect target, → S_REQ.
  - redirect_valid only: pc <= redirect target, → S_DROP.
- S_DROP:
  - Waits for the stale response. imem_rsp_valid: discard, → S_REQ.
  - A redirect in S_DROP updates pc and stays in S_DROP (the last redirect wins).
- S_HOLD:
  - inst_valid = !redirect_valid.
  - Redirect has priority: pc <= redirect target, the held instruction is dropped, → S_REQ, fetch_count unchanged.
  - Else inst_ready: pc <= inst_pc + 4 (wraps mod 2^XLEN), fetch_count += 1 (wraps), → S_REQ.
  - Else hold; inst/inst_pc remain stable.
- inst, opcode, funct3, funct7 and inst_pc are registered and stable whenever inst_valid=1. They hold their last value otherwise.
- Redirect alignment: loaded pc = {redirect_pc[XLEN-1:2], 2'b00}. If redirect_pc[1:0] != 0, misaligned_err <= 1; it clears only on reset.
- Latency:
  - Request acceptance in cycle N, response in N+1 → inst_valid in N+2.
  - Steady-state throughput with zero-wait memory and inst_ready=1 is one instruction per 3 cycles.
- At most one request is outstanding. imem_req_valid is 0 in every state except S_REQ.
- imem_rsp_valid arriving in S_REQ, S_HOLD or S_IDLE is a protocol violation and is ignored.
- Reset asserted mid-fetch returns all state to reset values immediately. An outstanding response arriving after reset release is ignored, because its state is S_IDLE/S_REQ.

Test Plan:
1. Release reset, memory ready=1, response 1 cycle later with data 32'h0000_0033 → first imem_req_addr=0 in cycle 1; inst_valid=1, opcode=7'b0110011, inst_pc=0 in cycle 3; next request addr=4.
2. inst_ready=0 for 5 cycles while inst=32'h4000_00B3 is held → inst_valid stays 1, inst/funct7=7'b0100000 stable, no new request issued, fetch_count=0; raise ready → fetch_count=1, imem_req_addr=4.
3. Redirect to 32'h0000_0100 in S_WAIT with no response, response arrives 2 cycles later → response discarded, inst_valid never asserts for it, next imem_req_addr=32'h100.
4. Redirect and imem_rsp_valid in the same S_WAIT cycle; redirect and inst_ready in the same S_HOLD cycle → data discarded / fetch_count unchanged; next request at redirect target.
5. Redirect to 32'h0000_0102 → next imem_req_addr=32'h100, misaligned_err=1 and still 1 after 10 cycles; pulse rst_n low → misaligned_err=0, pc=RESET_PC.
6. Assert rst_n low while in S_WAIT, then release with a late imem_rsp_valid → outputs are 0 during reset, the late response is ignored, and fetch restarts at RESET_PC after one S_IDLE cycle.
